mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the IF stage (instruction fetch)
//  and the MEM stage (ld/sd) of the 5-stage pipeline. Grants one requester at a time and holds
//  the memory handshake until completion. Drives stall_if / stall_mem into the hazard unit.
//  Data side has priority; a starvation counter guarantees fetch progress. A watchdog aborts hung accesses.
// PARAMETERS
//  XLEN        64   data width (register/memory word)
//  ADDR_W      64   address width
//  MAX_D_RUN   4    max consecutive D grants while if_req is pending before IF is forced
//  TIMEOUT     255  cycles in BUSY without mem_ready before abort (8-bit watchdog)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       fetch request, held high until if_valid
//  if_addr    in   ADDR_W  fetch address, stable while if_req
//  if_rdata   out  32      fetched instruction (mem_rdata[31:0])
//  if_valid   out  1       1-cycle pulse: if_rdata valid, fetch complete
//  d_req      in   1       data request, held high until d_valid
//  d_we       in   1       1=store (sd), 0=load (ld)
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   XLEN    store data
//  d_rdata    out  XLEN    load data
//  d_valid    out  1       1-cycle pulse: data access complete
//  stall_if   out  1       if_req & ~if_valid (combinational)
//  stall_mem  out  1       d_req & ~d_valid (combinational)
//  mem_req    out  1       memory request, held until mem_ready
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  XLEN    memory write data
//  mem_rdata  in   XLEN    memory read data, valid with mem_ready
//  mem_ready  in   1       access complete (any latency >= 1 cycle after mem_req rises)
//  err        out  1       1-cycle pulse with the valid of an aborted (timed-out) access
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, mem_we, if_valid, d_valid, err = 0; mem_addr, mem_wdata,
//    if_rdata, d_rdata, d_run, wdog = 0. Reset mid-access drops the access; no valid is produced.
//  - FSM IDLE / BUSY_I / BUSY_D. All mem_* outputs are registered.
//  - IDLE: d_req & ~(if_req & d_run==MAX_D_RUN) -> BUSY_D, latch d_addr/d_we/d_wdata onto mem_*;
//    else if_req -> BUSY_I, latch if_addr, mem_we=0; else stay. mem_req=1 on entry to BUSY_x.
//  - BUSY_x: mem_req/addr/we/wdata held constant. On mem_ready: mem_req=0, x_valid=1 next cycle,
//    rdata registered from mem_rdata (d_rdata unchanged on a store), state->IDLE.
//  - Min latency: request seen in IDLE at cycle N -> mem_req at N+1 -> mem_ready earliest N+1
//    -> x_valid at N+2. Back-to-back: IDLE at least one cycle between accesses.
//  - A requester must drop or renew its request the cycle after its valid; a req still high
//    in IDLE after valid is a new access.
//  - Starvation: d_run increments on each D grant made while if_req=1; cleared on any I grant
//    or a D grant with if_req=0; saturates at MAX_D_RUN. d_req and if_req simultaneous with
//    d_run<MAX_D_RUN -> D wins.
//  - Watchdog: wdog counts BUSY cycles, cleared on entry to BUSY. Reaching TIMEOUT without
//    mem_ready: mem_req=0, x_valid=1 and err=1 same cycle, rdata=0, state->IDLE.
//  - mem_ready while IDLE is ignored. stall_* fall in the valid cycle so the pipeline advances.
// TESTING
//  1. Reset: rst=1 two cycles -> all outputs 0, state IDLE; release, no req -> mem_req stays 0.
//  2. Load: d_req,d_we=0,d_addr=0x10, mem_ready 3 cycles after mem_req with rdata=42
//     -> d_valid pulse 1 cycle later, d_rdata=42, stall_mem low that cycle.
//  3. Conflict: if_req & d_req same cycle -> D granted first; IF served next, if_rdata=0x00500093.
//  4. Starvation: d_req held continuously with if_req high, MAX_D_RUN=4
//     -> 4 D grants then 1 I grant, d_run back to 0.
//  5. Timeout: TIMEOUT=8, mem_ready never -> after 8 BUSY cycles err=1 & if_valid=1,
//     if_rdata=0, mem_req=0.
//  6. Reset mid-access: rst during BUSY_D -> no d_valid; later mem_ready ignored; next access ok.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the shared memory port of the
// IF/MEM memory arbiter.
//   if_*   : instruction fetch request / response
//   d_*    : data (ld/sd) request / response
//   stall_*: hazard-unit stall requests
//   mem_*  : single-ported variable-latency memory handshake
//   err    : pulse flagging an access aborted by the watchdog
// slave  : arbiter view (receives requests, drives memory side)
// master : environment view (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN-1:0]   d_rdata;
    logic              d_valid;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between instruction fetch
// and the data stage. Data requests win ties, but after MAX_D_RUN consecutive
// data grants taken while a fetch waits, the fetch is forced through. A watchdog
// aborts any access that sees no mem_ready within TIMEOUT busy cycles.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data, stall and memory signals)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 64,
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    localparam int              RUN_W     = $clog2(MAX_D_RUN + 1);
    localparam logic [RUN_W-1:0] MAX_RUN_C = RUN_W'(MAX_D_RUN);
    localparam logic [7:0]      WDOG_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic [RUN_W-1:0]  d_run_q, d_run_d;
    logic [7:0]        wdog_q, wdog_d;

    // Arbitration, memory handshake, watchdog and starvation bookkeeping.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        d_run_d     = d_run_q;
        wdog_d      = wdog_q;

        case (state_q)
            ST_IDLE: begin
                // The valid cycle is a forced gap: the finished requester still
                // holds its req, so nothing is granted until the next cycle.
                if (if_valid_q || d_valid_q) begin
                    state_d = ST_IDLE;
                end else if (bus.d_req && !(bus.if_req && (d_run_q == MAX_RUN_C))) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    wdog_d      = 8'd0;
                    // Count only grants that made a waiting fetch lose; saturate.
                    if (!bus.if_req) begin
                        d_run_d = '0;
                    end else if (d_run_q != MAX_RUN_C) begin
                        d_run_d = d_run_q + RUN_W'(1);
                    end else begin
                        d_run_d = d_run_q;
                    end
                end else if (bus.if_req) begin
                    state_d    = ST_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    wdog_d     = 8'd0;
                    d_run_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == ST_BUSY_I) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata[31:0];
                    end else begin
                        d_valid_d = 1'b1;
                        // A store leaves the last load result in place.
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // Hung access: complete it with zero data and flag err.
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == ST_BUSY_I) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = 32'd0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= '0;
            d_run_q     <= '0;
            wdog_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            d_run_q     <= d_run_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    // Stalls drop in the valid cycle so the pipeline advances on it.
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;
    localparam int MAXR   = 4;
    localparam int TO     = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_D_RUN(MAXR), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // random-phase model state
    logic [63:0] mem_m [8];
    logic [63:0] d_rdata_m, exp_rd, cur_addr, cur_wdata;
    logic        cur_we, elig_i, elig_d, resp_act;
    int          exp_owner, vo, owner, winner, lat, cnt, run_m, i_age, d_age;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Memory answers lat cycles after the current cycle; ends in the valid cycle.
    task automatic respond(input int l, input logic [63:0] data);
        repeat (l) cyc();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = data;
        cyc();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'd0;
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(bus.mem_req), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 64'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 64'd0; bus.d_wdata = 64'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 64'd0;

        // 1. reset
        repeat (2) @(posedge clk);
        cyc();
        chk("rst_mem_req",   64'(bus.mem_req), 64'd0);
        chk("rst_mem_we",    64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr",  bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst_if_valid",  64'(bus.if_valid), 64'd0);
        chk("rst_d_valid",   64'(bus.d_valid), 64'd0);
        chk("rst_err",       64'(bus.err), 64'd0);
        chk("rst_if_rdata",  64'(bus.if_rdata), 64'd0);
        chk("rst_d_rdata",   bus.d_rdata, 64'd0);
        chk("rst_stall_if",  64'(bus.stall_if), 64'd0);
        chk("rst_stall_mem", 64'(bus.stall_mem), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("idle_no_req", 64'(bus.mem_req), 64'd0);
        end

        // 2. load, mem_ready three cycles after mem_req
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h10;
        #1 chk("load_stall_mem", 64'(bus.stall_mem), 64'd1);
        cyc();
        chk("load_mem_req",  64'(bus.mem_req), 64'd1);
        chk("load_mem_addr", bus.mem_addr, 64'h10);
        chk("load_mem_we",   64'(bus.mem_we), 64'd0);
        respond(3, 64'd42);
        chk("load_d_valid",   64'(bus.d_valid), 64'd1);
        chk("load_d_rdata",   bus.d_rdata, 64'd42);
        chk("load_stall_mem_valid", 64'(bus.stall_mem), 64'd0);
        chk("load_req_drop",  64'(bus.mem_req), 64'd0);
        bus.d_req = 1'b0;
        cyc();
        chk("load_valid_pulse", 64'(bus.d_valid), 64'd0);

        // 3. conflict: data wins, fetch served next
        bus.if_req = 1'b1; bus.if_addr = 64'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h20; bus.d_wdata = 64'hDEAD;
        cyc();
        chk("conf_d_first_addr", bus.mem_addr, 64'h20);
        chk("conf_d_we",         64'(bus.mem_we), 64'd1);
        chk("conf_d_wdata",      bus.mem_wdata, 64'hDEAD);
        respond(1, 64'h1234);
        chk("conf_d_valid",   64'(bus.d_valid), 64'd1);
        chk("conf_store_rd",  bus.d_rdata, 64'd42);
        chk("conf_if_wait",   64'(bus.if_valid), 64'd0);
        bus.d_req = 1'b0;
        #1 chk("conf_stall_if", 64'(bus.stall_if), 64'd1);
        wait_grant("conf_i_grant");
        chk("conf_i_addr", bus.mem_addr, 64'h100);
        chk("conf_i_we",   64'(bus.mem_we), 64'd0);
        respond(0, 64'hFFFF_FFFF_0050_0093);
        chk("conf_if_valid",  64'(bus.if_valid), 64'd1);
        chk("conf_if_rdata",  64'(bus.if_rdata), 64'h0050_0093);
        chk("conf_stall_if_v", 64'(bus.stall_if), 64'd0);
        bus.if_req = 1'b0;
        cyc();

        // 4. starvation: D,D,D,D,I then the run restarts
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h30;
        bus.if_req = 1'b1; bus.if_addr = 64'h200;
        for (int g = 0; g < 10; g++) begin
            wait_grant("starv_grant");
            chk("starv_owner", bus.mem_addr, (g % 5 == 4) ? 64'h200 : 64'h30);
            respond(0, 64'hA0 + 64'(g));
            chk("starv_if_valid", 64'(bus.if_valid), (g % 5 == 4) ? 64'd1 : 64'd0);
            chk("starv_d_valid",  64'(bus.d_valid),  (g % 5 == 4) ? 64'd0 : 64'd1);
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        cyc();

        // 5. watchdog: no mem_ready, abort after TO busy cycles
        bus.if_req = 1'b1; bus.if_addr = 64'h300;
        cyc();
        chk("to_mem_req", 64'(bus.mem_req), 64'd1);
        for (int k = 0; k < TO - 1; k++) begin
            cyc();
            chk("to_busy_req", 64'(bus.mem_req), 64'd1);
            chk("to_busy_err", 64'(bus.err), 64'd0);
        end
        cyc();
        chk("to_err",      64'(bus.err), 64'd1);
        chk("to_if_valid", 64'(bus.if_valid), 64'd1);
        chk("to_if_rdata", 64'(bus.if_rdata), 64'd0);
        chk("to_mem_req0", 64'(bus.mem_req), 64'd0);
        bus.if_req = 1'b0;
        cyc();
        chk("to_err_pulse", 64'(bus.err), 64'd0);

        // 6. reset mid-access
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h40;
        cyc();
        chk("mr_mem_req", 64'(bus.mem_req), 64'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.d_req = 1'b0;
        chk("mr_req_dropped", 64'(bus.mem_req), 64'd0);
        chk("mr_no_valid",    64'(bus.d_valid), 64'd0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'h77;
        cyc();
        bus.mem_ready = 1'b0;
        chk("mr_ready_ignored", 64'(bus.d_valid), 64'd0);
        cyc();
        chk("mr_no_valid2", 64'(bus.d_valid), 64'd0);
        chk("mr_idle",      64'(bus.mem_req), 64'd0);
        chk("mr_d_rdata",   bus.d_rdata, 64'd0);
        bus.d_req = 1'b1; bus.d_addr = 64'h48;
        wait_grant("mr_next_grant");
        chk("mr_next_addr", bus.mem_addr, 64'h48);
        respond(2, 64'h99);
        chk("mr_next_valid", 64'(bus.d_valid), 64'd1);
        chk("mr_next_rdata", bus.d_rdata, 64'h99);
        bus.d_req = 1'b0;
        cyc();

        // 7. randomized traffic against a transaction-level model
        for (int i = 0; i < 8; i++) mem_m[i] = {$urandom, $urandom};
        d_rdata_m = 64'h99; exp_owner = 0; resp_act = 1'b0; run_m = 0;
        elig_i = 1'b0; elig_d = 1'b0; i_age = 0; d_age = 0;
        cur_we = 1'b0; cur_addr = 64'd0; cur_wdata = 64'd0; exp_rd = 64'd0;
        owner = 0; lat = 0; cnt = 0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            vo = exp_owner;
            exp_owner = 0;
            chk("r_if_valid", 64'(bus.if_valid), (vo == 1) ? 64'd1 : 64'd0);
            chk("r_d_valid",  64'(bus.d_valid),  (vo == 2) ? 64'd1 : 64'd0);
            chk("r_err",      64'(bus.err), 64'd0);
            if (vo == 1) chk("r_if_rdata", 64'(bus.if_rdata), {32'd0, exp_rd[31:0]});
            if (vo == 2) begin
                if (!cur_we) d_rdata_m = exp_rd;
                chk("r_d_rdata", bus.d_rdata, d_rdata_m);
            end
            // grant: who should have won in the preceding arbitration cycle
            if (bus.mem_req === 1'b1 && !resp_act) begin
                chk("r_grant_eligible", 64'(elig_i | elig_d), 64'd1);
                winner = (elig_d && !(elig_i && run_m == MAXR)) ? 2 : 1;
                if (winner == 2) begin
                    cur_addr = bus.d_addr; cur_we = bus.d_we; cur_wdata = bus.d_wdata;
                    run_m = elig_i ? ((run_m < MAXR) ? run_m + 1 : MAXR) : 0;
                end else begin
                    cur_addr = bus.if_addr; cur_we = 1'b0; cur_wdata = 64'd0;
                    run_m = 0;
                end
                chk("r_grant_addr", bus.mem_addr, cur_addr);
                chk("r_grant_we",   64'(bus.mem_we), 64'(cur_we));
                if (cur_we) chk("r_grant_wdata", bus.mem_wdata, cur_wdata);
                resp_act = 1'b1; owner = winner; cnt = 0;
                lat = $urandom_range(0, 5);
            end else if (resp_act) begin
                chk("r_req_held",  64'(bus.mem_req), 64'd1);
                chk("r_addr_held", bus.mem_addr, cur_addr);
            end
            // memory responder; stray mem_ready only while the arbiter is idle
            bus.mem_ready = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
            if (resp_act) begin
                if (cnt == lat) begin
                    if (!cur_we) bus.mem_rdata = mem_m[cur_addr[5:3]];
                    else mem_m[cur_addr[5:3]] = cur_wdata;
                    exp_rd = bus.mem_rdata;
                    exp_owner = owner;
                    resp_act = 1'b0;
                    bus.mem_ready = 1'b1;
                end else begin
                    cnt++;
                end
            end else if (bus.mem_req === 1'b0 && $urandom_range(0, 3) == 0) begin
                bus.mem_ready = 1'b1;
            end
            // requesters: hold until valid, then drop or renew
            if (vo == 1 || !bus.if_req) begin
                bus.if_req  = ($urandom_range(0, 1) == 1);
                bus.if_addr = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd8;
            end
            if (vo == 2 || !bus.d_req) begin
                bus.d_req   = ($urandom_range(0, 1) == 1);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd8;
                bus.d_wdata = {$urandom, $urandom};
            end
            elig_i = bus.if_req && (vo == 0);
            elig_d = bus.d_req && (vo == 0);
            i_age = (bus.if_req && vo != 1) ? i_age + 1 : 0;
            d_age = (bus.d_req && vo != 2) ? d_age + 1 : 0;
            chk("r_if_progress", 64'(i_age < 60), 64'd1);
            chk("r_d_progress",  64'(d_age < 60), 64'd1);
            #1;
            chk("r_stall_if",  64'(bus.stall_if),  64'(bus.if_req && vo != 1));
            chk("r_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req && vo != 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
